// File: rtl/plot_arbiter.sv
// -----------------------------------------------------------------------------
// plot_arbiter
//
// Arbitrates NUM_REQ pixel producers onto a single VGA-adapter write port.
// A requester that wins arbitration owns the port until it drops req; every
// cycle in which the owner holds req with its grant high, one pixel is taken
// and presented on x/y/colour with plot=1 on the following cycle. A pixel
// whose x or y falls outside the display is consumed but not plotted; such
// pixels are counted in a saturating drop counter.
//
// Build option:
//   PLOT_ARB_ROUND_ROBIN_EN  defined   -> round-robin arbitration starting
//                                        after the last winner (registered
//                                        pointer)
//                            undefined -> fixed priority, lowest index wins
//
// Parameters:
//   NUM_REQ   number of requesters (2..8)
//   X_LIMIT   exclusive upper bound of a valid x coordinate
//   Y_LIMIT   exclusive upper bound of a valid y coordinate
//
// Ports:
//   clock       in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   req         in   per-requester pixel valid
//   req_x       in   packed x, requester i at [9i+8:9i]
//   req_y       in   packed y, requester i at [8i+7:8i]
//   req_colour  in   packed colour, requester i at [3i+2:3i]
//   gnt         out  registered one-hot grant, doubles as pixel-ready
//   plot        out  registered write enable to the VGA adapter
//   x, y        out  registered pixel coordinates
//   colour      out  registered pixel colour
//   busy        out  high while a requester owns the port
//   drop_cnt    out  saturating count of discarded out-of-range pixels
// -----------------------------------------------------------------------------
module plot_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned X_LIMIT = 320,
    parameter int unsigned Y_LIMIT = 240
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [9*NUM_REQ-1:0]   req_x,
    input  logic [8*NUM_REQ-1:0]   req_y,
    input  logic [3*NUM_REQ-1:0]   req_colour,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   plot,
    output logic [8:0]             x,
    output logic [7:0]             y,
    output logic [2:0]             colour,
    output logic                   busy,
    output logic [7:0]             drop_cnt
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    // One bit wider than the coordinate so that limits equal to 2^width
    // (e.g. Y_LIMIT=256) still compare correctly.
    localparam logic [9:0] X_LIM = 10'(X_LIMIT);
    localparam logic [8:0] Y_LIM = 9'(Y_LIMIT);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t               state;
    logic                 armed;
    logic [IW-1:0]        win_idx;
    logic                 win_found;
    logic [NUM_REQ-1:0]   win_onehot;
    logic [8:0]           sel_x;
    logic [7:0]           sel_y;
    logic [2:0]           sel_colour;
    logic                 accept;
    logic                 in_range;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
`ifdef PLOT_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] rr_ptr;

    // Search upward from the slot after the previous winner, wrapping.
    always_comb begin : rr_search
        int unsigned k;
        logic [IW-1:0] cand;
        win_idx   = '0;
        win_found = 1'b0;
        k         = 0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k    = (32'(rr_ptr) + 32'd1 + i) % NUM_REQ;
            cand = IW'(k);
            if (!win_found && req[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req[i]) begin
                win_idx   = IW'(i);
                win_found = 1'b1;
            end
        end
    end
`endif

    assign win_onehot = NUM_REQ'(1) << win_idx;

    // ------------------------------------------------------------------
    // Pixel mux from the current owner (gnt is one-hot or zero)
    // ------------------------------------------------------------------
    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_x      = req_x[9*i +: 9];
                sel_y      = req_y[8*i +: 8];
                sel_colour = req_colour[3*i +: 3];
            end
        end
    end

    assign accept   = (state == OWN) && (|(req & gnt));
    assign in_range = ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);
    assign busy     = (state != IDLE);

    // ------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------
    // armed holds off arbitration for the first edge after reset release,
    // so no grant can appear before the second rising edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            armed    <= 1'b0;
            gnt      <= '0;
            plot     <= 1'b0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
            drop_cnt <= '0;
`ifdef PLOT_ARB_ROUND_ROBIN_EN
            rr_ptr   <= '0;
`endif
        end else begin
            armed <= 1'b1;
            plot  <= 1'b0;
            case (state)
                IDLE: begin
                    if (armed && win_found) begin
                        gnt   <= win_onehot;
                        state <= OWN;
`ifdef PLOT_ARB_ROUND_ROBIN_EN
                        rr_ptr <= win_idx;
`endif
                    end else begin
                        gnt <= '0;
                    end
                end
                OWN: begin
                    if (accept) begin
                        if (in_range) begin
                            plot   <= 1'b1;
                            x      <= sel_x;
                            y      <= sel_y;
                            colour <= sel_colour;
                        end else if (drop_cnt != 8'hFF) begin
                            drop_cnt <= drop_cnt + 8'd1;
                        end
                    end else begin
                        // Owner released: one dead cycle in IDLE before
                        // the next arbitration.
                        gnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
